// File: rtl/systolic_pkg.sv
// Shared defaults, inner-dimension width helper and control FSM states for the skew feeder.
package systolic_pkg;

  localparam int unsigned DefaultSize   = 8;
  localparam int unsigned DefaultDwidth = 8;
  localparam int unsigned DefaultMaxK   = 8;

  // Width needed to hold any beat count from 0 to max_k inclusive.
  function automatic int unsigned kw_for(input int unsigned max_k);
    return $clog2(max_k + 1);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand beat bus from the A/B operand buffers into the skew feeder.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE   = DefaultSize,
  parameter int unsigned DWIDTH = DefaultDwidth
);

  logic [SIZE*DWIDTH-1:0] a_data;
  logic [SIZE*DWIDTH-1:0] b_data;
  logic                   a_valid;
  logic                   b_valid;
  logic                   in_ready;

  modport master (
    output a_data,
    output b_data,
    output a_valid,
    output b_valid,
    input  in_ready
  );

  modport slave (
    input  a_data,
    input  b_data,
    input  a_valid,
    input  b_valid,
    output in_ready
  );

endinterface

// File: rtl/skew_delay_bank.sv
// Per-lane masking and staircase delay: lane i holds i+1 registers so that lane i
// presents each injected element i+1 cycles after it was injected.
module skew_delay_bank #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned DWIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_clear,
  input  logic                   i_inject,
  input  logic                   i_beat_en,
  input  logic [SIZE-1:0]        i_lane_en,
  input  logic [SIZE*DWIDTH-1:0] i_data,
  output logic [SIZE*DWIDTH-1:0] o_data,
  output logic [SIZE-1:0]        o_valid
);

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DWIDTH-1:0] w_elem;
    logic [DWIDTH-1:0] r_data  [i+1];
    logic              r_valid [i+1];

    // Non-injecting cycles push a zero bubble; masked beats stay valid but carry zero.
    assign w_elem = i_inject ?
                    (i_data[i*DWIDTH +: DWIDTH] & {DWIDTH{i_lane_en[i] & i_beat_en}}) : '0;

    // Shift the lane chain every cycle; clear flushes it outside an operation.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int j = 0; j <= i; j++) begin
          r_data[j]  <= '0;
          r_valid[j] <= 1'b0;
        end
      end else if (i_clear) begin
        for (int j = 0; j <= i; j++) begin
          r_data[j]  <= '0;
          r_valid[j] <= 1'b0;
        end
      end else begin
        r_data[0]  <= w_elem;
        r_valid[0] <= i_inject;
        for (int j = 1; j <= i; j++) begin
          r_data[j]  <= r_data[j-1];
          r_valid[j] <= r_valid[j-1];
        end
      end
    end

    assign o_data[i*DWIDTH +: DWIDTH] = r_data[i];
    assign o_valid[i]                 = r_valid[i];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an NxN output-stationary systolic array: streams num_k masked
// A/B beats, skews lane i by i+1 cycles, drains the staircase, then pulses done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE   = DefaultSize,
  parameter int unsigned DWIDTH = DefaultDwidth,
  parameter int unsigned MAX_K  = DefaultMaxK,
  localparam int unsigned KW    = kw_for(MAX_K)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [KW-1:0]          i_num_k,
  systolic_skew_feeder_if.slave  bus_if,
  input  logic [SIZE-1:0]        i_mask_a_rows,
  input  logic [SIZE-1:0]        i_mask_b_cols,
  input  logic [MAX_K-1:0]       i_mask_a_cols,
  input  logic [MAX_K-1:0]       i_mask_b_rows,
  output logic [SIZE*DWIDTH-1:0] o_a_skew,
  output logic [SIZE*DWIDTH-1:0] o_b_skew,
  output logic [SIZE-1:0]        o_skew_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned      DW        = $clog2(SIZE + 1);
  localparam logic [KW-1:0]    KOne      = KW'(1);
  localparam logic [KW-1:0]    KMax      = KW'(MAX_K);
  localparam logic [DW-1:0]    DrainLast = DW'(SIZE - 1);

  state_e            r_state, w_state_d;
  logic [KW-1:0]     r_k, w_k_d, r_num_k, w_num_k_in;
  logic [DW-1:0]     r_drain, w_drain_d;
  logic [SIZE-1:0]   r_mask_a_rows, r_mask_b_cols;
  logic [MAX_K-1:0]  r_mask_a_cols, r_mask_b_rows;
  logic [MAX_K-1:0]  w_a_cols_sh, w_b_rows_sh;
  logic [SIZE-1:0]   w_a_valid, w_b_valid;
  logic              w_latch, w_accept, w_clear, w_in_ready;

  assign w_num_k_in = (i_num_k > KMax) ? KMax : i_num_k;
  assign w_in_ready = (r_state == StStream);
  assign w_accept   = w_in_ready & bus_if.a_valid & bus_if.b_valid;
  assign w_clear    = (r_state == StIdle) | (r_state == StDone);

  // Per-beat enables come from bit k of the latched column/row masks.
  assign w_a_cols_sh = r_mask_a_cols >> r_k;
  assign w_b_rows_sh = r_mask_b_rows >> r_k;

  assign bus_if.in_ready = w_in_ready;
  assign o_busy          = (r_state == StStream) | (r_state == StDrain);
  assign o_done          = (r_state == StDone);
  assign o_skew_valid    = w_a_valid & w_b_valid;

  // Next-state, beat counter and drain counter.
  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    w_drain_d = r_drain;
    w_latch   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_num_k == '0) begin
            w_state_d = StDone;
          end else begin
            w_latch   = 1'b1;
            w_k_d     = '0;
            w_state_d = StStream;
          end
        end
      end
      StStream: begin
        if (w_accept) begin
          w_k_d = r_k + KOne;
          if ((r_k + KOne) == r_num_k) begin
            w_drain_d = '0;
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (r_drain == DrainLast) begin
          w_state_d = StDone;
        end else begin
          w_drain_d = r_drain + DW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State, counters, and operation parameters captured on an accepted start.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_k           <= '0;
      r_drain       <= '0;
      r_num_k       <= '0;
      r_mask_a_rows <= '0;
      r_mask_b_cols <= '0;
      r_mask_a_cols <= '0;
      r_mask_b_rows <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
      r_drain <= w_drain_d;
      if (w_latch) begin
        r_num_k       <= w_num_k_in;
        r_mask_a_rows <= i_mask_a_rows;
        r_mask_b_cols <= i_mask_b_cols;
        r_mask_a_cols <= i_mask_a_cols;
        r_mask_b_rows <= i_mask_b_rows;
      end
    end
  end

  skew_delay_bank #(
    .SIZE   (SIZE),
    .DWIDTH (DWIDTH)
  ) u_bank_a (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_clear),
    .i_inject  (w_accept),
    .i_beat_en (w_a_cols_sh[0]),
    .i_lane_en (r_mask_a_rows),
    .i_data    (bus_if.a_data),
    .o_data    (o_a_skew),
    .o_valid   (w_a_valid)
  );

  skew_delay_bank #(
    .SIZE   (SIZE),
    .DWIDTH (DWIDTH)
  ) u_bank_b (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_clear),
    .i_inject  (w_accept),
    .i_beat_en (w_b_rows_sh[0]),
    .i_lane_en (r_mask_b_cols),
    .i_data    (bus_if.b_data),
    .o_data    (o_b_skew),
    .o_valid   (w_b_valid)
  );

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (SIZE=4, DWIDTH=8, MAX_K=8): directed
// scenarios plus randomized operations, checked every cycle against a beat-level model.
module tb_systolic_skew_feeder;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned MK = 8;
  localparam int unsigned KW = $clog2(MK + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   num_k = '0;
  logic [N-1:0]    mask_a_rows = '1, mask_b_cols = '1;
  logic [MK-1:0]   mask_a_cols = '1, mask_b_rows = '1;
  logic [N*W-1:0]  a_skew, b_skew;
  logic [N-1:0]    skew_valid;
  logic            busy, done;

  systolic_skew_feeder_if #(.SIZE(N), .DWIDTH(W)) bus ();

  systolic_skew_feeder #(.SIZE(N), .DWIDTH(W), .MAX_K(MK)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_num_k       (num_k),
    .bus_if        (bus),
    .i_mask_a_rows (mask_a_rows),
    .i_mask_b_cols (mask_b_cols),
    .i_mask_a_cols (mask_a_cols),
    .i_mask_b_rows (mask_b_rows),
    .o_a_skew      (a_skew),
    .o_b_skew      (b_skew),
    .o_skew_valid  (skew_valid),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: remaining beats, remaining drain cycles, pending done, and the
  // vectors injected over the last N cycles (index 0 = previous cycle).
  int             m_beats, m_drain, m_k;
  bit             m_done;
  logic [N-1:0]   m_rows_a, m_cols_b;
  logic [MK-1:0]  m_cols_a, m_rows_b;
  logic [N*W-1:0] h_a [N];
  logic [N*W-1:0] h_b [N];
  logic           h_v [N];
  int             n_checks = 0, n_fails = 0, dut_accepts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_beats = 0; m_drain = 0; m_k = 0; m_done = 0;
    for (int i = 0; i < N; i++) begin
      h_a[i] = '0; h_b[i] = '0; h_v[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] ea, eb;
    logic [N-1:0]   ev;
    for (int i = 0; i < N; i++) begin
      ea[i*W +: W] = h_a[i][i*W +: W];
      eb[i*W +: W] = h_b[i][i*W +: W];
      ev[i]        = h_v[i];
    end
    check("in_ready",   64'(bus.in_ready), 64'(m_beats > 0));
    check("busy",       64'(busy),         64'((m_beats > 0) || (m_drain > 0)));
    check("done",       64'(done),         64'(m_done));
    check("a_skew",     64'(a_skew),       64'(ea));
    check("b_skew",     64'(b_skew),       64'(eb));
    check("skew_valid", 64'(skew_valid),   64'(ev));
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model, step edge.
  task automatic tick();
    logic [N*W-1:0] ia, ib;
    bit             acc, ea_en, eb_en;
    int             n;
    @(negedge clk);
    check_outputs();
    if (bus.in_ready && bus.a_valid && bus.b_valid) dut_accepts++;
    acc = (m_beats > 0) && bus.a_valid && bus.b_valid;
    ia = '0; ib = '0;
    if (acc) begin
      ea_en = ((m_cols_a >> m_k) & 1) != 0;
      eb_en = ((m_rows_b >> m_k) & 1) != 0;
      for (int i = 0; i < N; i++) begin
        ia[i*W +: W] = bus.a_data[i*W +: W] & {W{m_rows_a[i] & ea_en}};
        ib[i*W +: W] = bus.b_data[i*W +: W] & {W{m_cols_b[i] & eb_en}};
      end
    end
    for (int i = N - 1; i > 0; i--) begin
      h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; h_v[i] = h_v[i-1];
    end
    h_a[0] = ia; h_b[0] = ib; h_v[0] = acc;
    if (!rst_n) begin
      model_clear();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_beats > 0) begin
      if (acc) begin
        m_k++; m_beats--;
        if (m_beats == 0) m_drain = N;
      end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_done = 1;
    end else if (start) begin
      n = (int'(num_k) > MK) ? MK : int'(num_k);
      if (n == 0) begin
        m_done = 1;
      end else begin
        m_beats = n; m_k = 0;
        m_rows_a = mask_a_rows; m_cols_b = mask_b_cols;
        m_cols_a = mask_a_cols; m_rows_b = mask_b_rows;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // dmode: 0 = lane i beat k is 0x10*k+i (B 0x80 offset), 1 = random, 2 = all 0xFF.
  task automatic drive_data(input int dmode);
    for (int i = 0; i < N; i++) begin
      case (dmode)
        0: begin
          bus.a_data[i*W +: W] = W'(16 * m_k + i);
          bus.b_data[i*W +: W] = W'(128 + 16 * m_k + i);
        end
        2: begin
          bus.a_data[i*W +: W] = 8'hFF;
          bus.b_data[i*W +: W] = 8'hFF;
        end
        default: begin
          bus.a_data[i*W +: W] = W'($urandom_range(0, 255));
          bus.b_data[i*W +: W] = W'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  task automatic randomize_masks();
    mask_a_rows = N'($urandom()); mask_b_cols = N'($urandom());
    mask_a_cols = MK'($urandom()); mask_b_rows = MK'($urandom());
  endtask

  // vmode: 0 = both valids high, 1 = b_valid low in relative cycle 2, 2 = random valids.
  task automatic run_op(input int n, input int vmode, input int dmode, input bit mid_start,
                        input bit live_masks);
    int c;
    start = 1'b1; num_k = KW'(n);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    drive_data(dmode);
    tick();
    start = 1'b0;
    c = 1;
    while (c < 60 && (m_beats > 0 || m_drain > 0 || m_done)) begin
      case (vmode)
        0: begin bus.a_valid = 1'b1; bus.b_valid = 1'b1; end
        1: begin bus.a_valid = 1'b1; bus.b_valid = (c != 2); end
        default: begin
          bus.a_valid = ($urandom_range(0, 3) != 0);
          bus.b_valid = ($urandom_range(0, 3) != 0);
        end
      endcase
      start = mid_start && (c == 2);
      num_k = KW'($urandom_range(1, 15));
      if (live_masks) randomize_masks();
      drive_data(dmode);
      tick();
      c++;
    end
    start = 1'b0;
    check("op_complete", 64'(c < 60), 64'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; bus.a_valid = $urandom_range(0, 1); bus.b_valid = $urandom_range(0, 1);
      drive_data(1);
      tick();
    end
  endtask

  int a0;

  initial begin
    model_clear();
    bus.a_data = '0; bus.b_data = '0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // Reset held with random inputs, then idle after release.
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      start = $urandom_range(0, 1); num_k = KW'($urandom_range(0, 15));
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      randomize_masks(); drive_data(1);
      tick();
    end
    start = 1'b0;
    rst_n = 1'b1;
    idle_cycles(5);

    // Full stream, num_k=4, patterned data.
    mask_a_rows = '1; mask_b_cols = '1; mask_a_cols = '1; mask_b_rows = '1;
    a0 = dut_accepts;
    run_op(4, 0, 0, 1'b0, 1'b0);
    check("full_accepts", 64'(dut_accepts - a0), 64'(4));

    // Bubble: b_valid low in relative cycle 2.
    a0 = dut_accepts;
    run_op(3, 1, 0, 1'b0, 1'b0);
    check("bubble_accepts", 64'(dut_accepts - a0), 64'(3));

    // Masks: A lane 2 off, A beat 1 off, data all 0xFF.
    mask_a_rows = 4'b1011; mask_a_cols = 8'b1111_1101;
    mask_b_cols = '1;      mask_b_rows = '1;
    run_op(2, 0, 2, 1'b0, 1'b0);
    mask_a_rows = '1; mask_a_cols = '1;

    // num_k = 0 completes immediately without busy.
    run_op(0, 0, 1, 1'b0, 1'b0);

    // num_k beyond MAX_K is clamped.
    a0 = dut_accepts;
    run_op(15, 0, 1, 1'b0, 1'b0);
    check("clamp_accepts", 64'(dut_accepts - a0), 64'(MK));

    // start pulsed during STREAM is ignored.
    a0 = dut_accepts;
    run_op(5, 0, 1, 1'b1, 1'b0);
    check("midstart_accepts", 64'(dut_accepts - a0), 64'(5));

    // Reset asserted in cycle 3 of a num_k=4 stream.
    start = 1'b1; num_k = KW'(4); bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    drive_data(1);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(3);
    a0 = dut_accepts;
    run_op(4, 0, 0, 1'b0, 1'b0);
    check("post_reset_accepts", 64'(dut_accepts - a0), 64'(4));

    // Randomized operations with live-changing mask inputs and random valids.
    for (int op = 0; op < 12; op++) begin
      randomize_masks();
      run_op($urandom_range(0, 15), 2, 1, $urandom_range(0, 1), 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
